// File: rtl/in_port_ctrl_pkg.sv
// in_port_ctrl_pkg
// Shared constants for the input-port controller: the channel count, the select width and the
// channel index encodings. The encodings match the CPU input-mux select field, so a select
// value can be passed straight through without translation.
package in_port_ctrl_pkg;

    localparam int unsigned NCH   = 4;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] CH0 = 2'b00;
    localparam logic [SEL_W-1:0] CH1 = 2'b01;
    localparam logic [SEL_W-1:0] CH2 = 2'b10;
    localparam logic [SEL_W-1:0] CH3 = 2'b11;

    // One-hot decode of a channel select.
    function automatic logic [NCH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
        logic [NCH-1:0] oh;
        oh     = '0;
        oh[ch] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/in_port_ctrl_fifo2.sv
// in_fifo2
// Small per-channel receive FIFO (DEPTH entries, DEPTH a power of 2; 2 is the intended size).
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   wdata           - producer data
//   push_valid      - producer valid
//   push_ready      - ready to producer; from registered count only, forced low during reset
//   pop             - pop request (already decoded for this channel)
//   rdata           - head entry, zero when empty
//   nonempty        - FIFO holds at least one entry
//   underflow_pulse - pop requested while empty (this cycle)
// Storage is deliberately not reset; only pointers and count are.
module in_fifo2 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wdata,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             nonempty,
    output logic             underflow_pulse
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_fire;
    logic             pop_fire;

    assign push_ready      = (count_q != FULL) && !reset;
    assign nonempty        = (count_q != '0);
    assign push_fire       = push_valid && push_ready;
    // An empty pop is reported, never performed; a same-cycle push still lands.
    assign pop_fire        = pop && nonempty;
    assign underflow_pulse = pop && !nonempty;
    assign rdata           = nonempty ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/in_port_ctrl.sv
// in_port_ctrl
// Input-side peripheral interface: four producers push bytes over valid/ready into per-channel
// FIFOs; the CPU selects a channel, sees its head byte and pops it with rd_en.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   ext_data0..ext_data3    - producer data per channel
//   ext_valid / ext_ready   - per-channel handshake (bit i = channel i)
//   sel, rd_en              - CPU channel select and read strobe
//   cpu_data                - head byte of the selected channel, zero if it is empty
//   avail                   - per-channel non-empty
//   uflow                   - sticky per-channel empty-read flag, cleared only by reset
module in_port_ctrl
    import in_port_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ext_data0,
    input  logic [WIDTH-1:0] ext_data1,
    input  logic [WIDTH-1:0] ext_data2,
    input  logic [WIDTH-1:0] ext_data3,
    input  logic [NCH-1:0]   ext_valid,
    output logic [NCH-1:0]   ext_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic             rd_en,
    output logic [WIDTH-1:0] cpu_data,
    output logic [NCH-1:0]   avail,
    output logic [NCH-1:0]   uflow
);

    logic [WIDTH-1:0] ext_data [NCH];
    logic [WIDTH-1:0] head     [NCH];
    logic [NCH-1:0]   pop_vec;
    logic [NCH-1:0]   uflow_pulse;
    logic [NCH-1:0]   uflow_q, uflow_d;

    assign ext_data[0] = ext_data0;
    assign ext_data[1] = ext_data1;
    assign ext_data[2] = ext_data2;
    assign ext_data[3] = ext_data3;

    // rd_en only ever touches the selected channel.
    assign pop_vec = rd_en ? ch_onehot(sel) : '0;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        in_fifo2 #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk             (clk),
            .reset           (reset),
            .wdata           (ext_data[i]),
            .push_valid      (ext_valid[i]),
            .push_ready      (ext_ready[i]),
            .pop             (pop_vec[i]),
            .rdata           (head[i]),
            .nonempty        (avail[i]),
            .underflow_pulse (uflow_pulse[i])
        );
    end

    // Each FIFO already zeroes its head when empty, so a plain mux gives zero on an empty channel.
    assign cpu_data = head[sel];

    always_comb begin
        uflow_d = uflow_q | uflow_pulse;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uflow_q <= '0;
        end else begin
            uflow_q <= uflow_d;
        end
    end

    assign uflow = uflow_q;

endmodule

// File: tb/tb_in_port_ctrl.sv
module tb_in_port_ctrl;
    import in_port_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dat [4];
    logic [3:0] ext_valid;
    logic [3:0] ext_ready;
    logic [1:0] sel;
    logic       rd_en;
    logic [7:0] cpu_data;
    logic [3:0] avail;
    logic [3:0] uflow;

    int total = 0;
    int bad   = 0;

    // Reference model: each channel is an ordered list (index 0 = oldest) of up to 2 bytes.
    logic [7:0] mbuf [4][2];
    int         mcnt [4];
    logic [3:0] m_uflow;

    in_port_ctrl #(
        .WIDTH (8),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ext_data0 (dat[0]),
        .ext_data1 (dat[1]),
        .ext_data2 (dat[2]),
        .ext_data3 (dat[3]),
        .ext_valid (ext_valid),
        .ext_ready (ext_ready),
        .sel       (sel),
        .rd_en     (rd_en),
        .cpu_data  (cpu_data),
        .avail     (avail),
        .uflow     (uflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) mcnt[i] = 0;
        m_uflow = '0;
    endtask

    task automatic check_outputs();
        logic [3:0] e_ready;
        logic [3:0] e_avail;
        logic [7:0] e_data;
        for (int i = 0; i < 4; i++) begin
            e_ready[i] = !reset && (mcnt[i] != 2);
            e_avail[i] = (mcnt[i] != 0);
        end
        e_data = (mcnt[sel] != 0) ? mbuf[sel][0] : 8'h00;
        check("ready", ext_ready, e_ready);
        check("avail", avail, e_avail);
        check("cpu_data", cpu_data, e_data);
        check("uflow", uflow, m_uflow);
    endtask

    // One clock: check outputs against the model, let the edge happen, advance the model.
    task automatic cycle();
        logic [3:0] push;
        logic [3:0] popreq;
        #1 check_outputs();
        for (int i = 0; i < 4; i++) begin
            push[i]   = ext_valid[i] && (mcnt[i] != 2) && !reset;
            popreq[i] = rd_en && (sel == 2'(i));
        end
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (popreq[i]) begin
                    if (mcnt[i] == 0) begin
                        m_uflow[i] = 1'b1;
                    end else begin
                        mbuf[i][0] = mbuf[i][1];
                        mcnt[i]--;
                    end
                end
                if (push[i]) begin
                    mbuf[i][mcnt[i]] = dat[i];
                    mcnt[i]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        ext_valid = '0;
        rd_en     = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        sel       = CH0;
        for (int i = 0; i < 4; i++) dat[i] = 8'h00;
        idle();
        model_clear();
        @(negedge clk);
        #1 check("rst_ready_low", ext_ready, 4'b0000);
        cycle();
        reset = 1'b0;
        #1;
        check("post_rst_ready", ext_ready, 4'b1111);
        check("post_rst_avail", avail, 4'b0000);
        check("post_rst_uflow", uflow, 4'b0000);
        check("post_rst_data", cpu_data, 8'h00);
        cycle();

        // Channel 2: two pushes fill it, two reads drain it.
        dat[2] = 8'hA5; ext_valid = 4'b0100; cycle();
        dat[2] = 8'h3C; cycle();
        idle(); sel = CH2;
        #1 check("c2_full_ready", ext_ready[2], 1'b0);
        check("c2_head", cpu_data, 8'hA5);
        cycle();
        rd_en = 1'b1; cycle(); rd_en = 1'b0;
        #1 check("c2_second", cpu_data, 8'h3C);
        check("c2_ready_back", ext_ready[2], 1'b1);
        rd_en = 1'b1; cycle(); rd_en = 1'b0;
        #1 check("c2_empty_data", cpu_data, 8'h00);
        check("c2_empty_avail", avail[2], 1'b0);

        // Channel 0: full, producer holds 33 until a pop frees a slot.
        sel = CH0;
        dat[0] = 8'h11; ext_valid = 4'b0001; cycle();
        dat[0] = 8'h22; cycle();
        dat[0] = 8'h33; cycle();
        #1 check("c0_full_ready", ext_ready[0], 1'b0);
        rd_en = 1'b1; cycle(); rd_en = 1'b0;
        #1 check("c0_ready_rise", ext_ready[0], 1'b1);
        cycle();
        idle();
        #1 check("c0_read22", cpu_data, 8'h22);
        rd_en = 1'b1; cycle();
        #1 check("c0_read33", cpu_data, 8'h33);
        cycle(); rd_en = 1'b0;
        #1 check("c0_drained", avail[0], 1'b0);

        // Channel 1: push and pop together at count 1.
        sel = CH1;
        dat[1] = 8'h44; ext_valid = 4'b0010; cycle();
        dat[1] = 8'h55; rd_en = 1'b1; cycle();
        idle();
        #1 check("c1_data55", cpu_data, 8'h55);
        check("c1_avail", avail[1], 1'b1);
        check("c1_no_uflow", uflow[1], 1'b0);
        rd_en = 1'b1; cycle(); rd_en = 1'b0;

        // Channel 3: empty read is sticky and isolated; later data still flows.
        sel = CH3; rd_en = 1'b1; cycle(); rd_en = 1'b0;
        #1 check("c3_uflow", uflow, 4'b1000);
        cycle();
        #1 check("c3_uflow_sticky", uflow, 4'b1000);
        dat[3] = 8'h66; ext_valid = 4'b1000; cycle(); idle();
        #1 check("c3_data66", cpu_data, 8'h66);
        check("c3_uflow_still", uflow, 4'b1000);
        rd_en = 1'b1; cycle(); rd_en = 1'b0;

        // All channels at once, then reset mid-way through the reads.
        dat[0] = 8'h10; dat[1] = 8'h20; dat[2] = 8'h30; dat[3] = 8'h40;
        ext_valid = 4'b1111; cycle(); idle();
        sel = CH0; rd_en = 1'b1; cycle(); rd_en = 1'b0;
        sel = CH1;
        #1 check("all_ch1", cpu_data, 8'h20);
        sel = CH2; rd_en = 1'b1; ext_valid = 4'b0001;
        reset = 1'b1; model_clear();
        #1 check("mid_rst_ready", ext_ready, 4'b0000);
        cycle();
        idle(); reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1 check("rst_data_sel", cpu_data, 8'h00);
        end
        check("rst_avail", avail, 4'b0000);
        check("rst_uflow", uflow, 4'b0000);

        // Random traffic against the model, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
            ext_valid = 4'($urandom);
            sel       = 2'($urandom);
            rd_en     = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                model_clear();
            end else begin
                reset = 1'b0;
            end
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
